bch_decode_ctrl: RTL and testbench

- Sequencing controller for the BCH(15,7), t=2 decoder.
- Accepts one 15-bit received word per valid/ready handshake and registers it.
- Runs the word through the combinational syndrome block, solves the error-locator polynomial (Peterson, t=2) and runs a serial 15-cycle Chien search.
- Returns the corrected word with an error count and a failure flag. It sits between the demodulator's word buffer and the downstream payload unpacker.

---
 rtl/bch_pkg.sv | 50 +++++
 rtl/bch_syndrome_block.sv | 25 ++
 rtl/bch_decode_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bch_decode_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - GF(16) arithmetic, code constants and FSM states for the BCH(15,7) decoder
package bch_pkg;

  localparam int N = 15;
  localparam int K = 7;
  // Low four bits of x^4+x+1; x^4 folds back to x+1.
  localparam logic [3:0] GF_POLY = 4'b0011;

  // alpha^-1 = alpha^14 and alpha^-2 = alpha^13, used to step the Chien accumulators.
  localparam logic [3:0] ALPHA_M1 = 4'b1001;
  localparam logic [3:0] ALPHA_M2 = 4'b1101;

  typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, DONE} state_t;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'b0000;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ GF_POLY) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] alpha_pow(input int e);
    logic [3:0] r;
    int m;
    r = 4'b0001;
    m = e % 15;
    if (m < 0) m = m + 15;
    for (int i = 0; i < 14; i++) begin
      if (i < m) r = gf_mul(r, 4'b0010);
    end
    return r;
  endfunction

  // a^-1 = a^14 = a^8 * a^4 * a^2; zero maps to zero.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf_mul(a, a);
    a4 = gf_mul(a2, a2);
    a8 = gf_mul(a4, a4);
    return gf_mul(gf_mul(a8, a4), a2);
  endfunction

endpackage

// File: rtl/bch_syndrome_block.sv
// rtl/bch_syndrome_block.sv - combinational S1/S2/S3 syndromes of a 15-bit received word
module bch_syndrome_block
  import bch_pkg::*;
(
  input  logic [N-1:0] rx_word,
  output logic [3:0]   s1,
  output logic [3:0]   s2,
  output logic [3:0]   s3
);

  // Evaluate r(x) at alpha, alpha^2 and alpha^3 by summing the powers of the set bits.
  always_comb begin
    s1 = 4'b0000;
    s2 = 4'b0000;
    s3 = 4'b0000;
    for (int i = 0; i < N; i++) begin
      if (rx_word[i]) begin
        s1 = s1 ^ alpha_pow(i);
        s2 = s2 ^ alpha_pow(2 * i);
        s3 = s3 ^ alpha_pow(3 * i);
      end
    end
  end

endmodule

// File: rtl/bch_decode_ctrl.sv
// rtl/bch_decode_ctrl.sv - sequencing controller for the BCH(15,7) t=2 decoder
module bch_decode_ctrl
  import bch_pkg::*;
#(
  parameter bit FAST_CLEAN = 1'b0
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_nerr,
  output logic         out_fail
);

  state_t state;
  state_t state_nxt;

  logic [N-1:0] word_q;
  logic [N-1:0] raw_q;
  logic [3:0]   s1;
  logic [3:0]   s2;
  logic [3:0]   s3;
  logic [3:0]   s1_q;
  logic [3:0]   s3_q;
  logic [3:0]   t1_q;
  logic [3:0]   t2_q;
  logic [3:0]   idx_q;
  logic [1:0]   deg_q;
  logic [1:0]   root_cnt_q;
  logic         fail_q;

  logic [3:0]   cube;
  logic [3:0]   sig1;
  logic [3:0]   sig2;
  logic [1:0]   deg;
  logic         fail_c;
  logic         clean;
  logic         root;
  logic         res_fail;

  bch_syndrome_block u_synd (
    .rx_word (word_q),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3)
  );

  assign clean    = (s1_q == 4'b0000) && (s3_q == 4'b0000);
  assign root     = ((4'b0001 ^ t1_q ^ t2_q) == 4'b0000);
  assign res_fail = fail_q || (root_cnt_q != deg_q);

  // Peterson solve for t=2: classify the registered syndromes into locator degree and coefficients.
  always_comb begin
    cube   = gf_mul(gf_mul(s1_q, s1_q), s1_q);
    sig1   = 4'b0000;
    sig2   = 4'b0000;
    deg    = 2'd0;
    fail_c = 1'b0;
    if (s1_q == 4'b0000) begin
      fail_c = (s3_q != 4'b0000);
    end else if (s3_q == cube) begin
      deg  = 2'd1;
      sig1 = s1_q;
    end else begin
      deg  = 2'd2;
      sig1 = s1_q;
      sig2 = gf_mul(s3_q ^ cube, gf_inv(s1_q));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the Chien walk ends after index 14.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SYND;
      SYND:    state_nxt = SOLVE;
      SOLVE:   state_nxt = (FAST_CLEAN && clean) ? DONE : CHIEN;
      CHIEN:   if (idx_q == 4'd14) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch word, register syndromes, load locator, then flip bits at each Chien root.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      raw_q      <= '0;
      s1_q       <= 4'b0000;
      s3_q       <= 4'b0000;
      t1_q       <= 4'b0000;
      t2_q       <= 4'b0000;
      idx_q      <= 4'd0;
      deg_q      <= 2'd0;
      root_cnt_q <= 2'd0;
      fail_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word_q     <= in_data;
            raw_q      <= in_data;
            root_cnt_q <= 2'd0;
            deg_q      <= 2'd0;
            fail_q     <= 1'b0;
          end
        end
        SYND: begin
          s1_q <= s1;
          s3_q <= s3;
        end
        SOLVE: begin
          t1_q   <= sig1;
          t2_q   <= sig2;
          deg_q  <= deg;
          fail_q <= fail_c;
          idx_q  <= 4'd0;
        end
        CHIEN: begin
          if (root) begin
            word_q     <= word_q ^ (N'(1) << idx_q);
            root_cnt_q <= root_cnt_q + 2'd1;
          end
          t1_q <= gf_mul(t1_q, ALPHA_M1);
          t2_q <= gf_mul(t2_q, ALPHA_M2);
          if (idx_q != 4'd14) idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: handshake flags from state, result only while DONE, original word on failure.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_data  = '0;
    out_nerr  = 2'd0;
    out_fail  = 1'b0;
    if (state == DONE) begin
      out_fail = res_fail;
      out_data = res_fail ? raw_q : word_q;
      out_nerr = res_fail ? 2'd0 : root_cnt_q;
    end
  end

  // For a binary code S2 is always S1 squared; anything else means the syndrome block is broken.
  always @(posedge clk) begin
    if (!rst) assert (s2 == gf_mul(s1, s1));
  end

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// tb/tb_bch_decode_ctrl.sv - self-checking bench for bch_decode_ctrl
module tb_bch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [2];
  logic        ir   [2];
  logic [14:0] idt  [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [14:0] od   [2];
  logic [1:0]  on   [2];
  logic        of   [2];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [14:0] din;
    logic [14:0] dout;
    logic [1:0]  nerr;
    logic        fail;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  bch_decode_ctrl #(.FAST_CLEAN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idt[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .out_nerr(on[0]), .out_fail(of[0])
  );

  bch_decode_ctrl #(.FAST_CLEAN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idt[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .out_nerr(on[1]), .out_fail(of[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Codeword = message polynomial times g(x) = x^8+x^7+x^6+x^4+1 over GF(2).
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) begin
      if (m[i]) c = c ^ (15'h01D1 << i);
    end
    return c;
  endfunction

  // Reference: nearest codeword within Hamming distance 2, otherwise uncorrectable.
  task automatic ref_decode(input logic [14:0] r, output logic [14:0] d,
                            output logic [1:0] ne, output logic f);
    logic [14:0] cw;
    int w;
    d  = r;
    ne = 2'd0;
    f  = 1'b1;
    for (int m = 0; m < 128; m++) begin
      cw = encode(7'(m));
      w  = $countones(cw ^ r);
      if (w <= 2) begin
        d  = cw;
        ne = 2'(w);
        f  = 1'b0;
      end
    end
  endtask

  task automatic run(input int u, input logic [14:0] d, input logic [14:0] ed,
                     input logic [1:0] en, input logic ef, input int elat,
                     input int bp, input string tag);
    int n;
    int lat;
    @(negedge clk);
    iv[u]  = 1'b1;
    idt[u] = d;
    n = 0;
    while (!ir[u] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(ir[u]), 32'd1);
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_data"}, 32'(od[u]), 32'(ed));
    check({tag, "_nerr"}, 32'(on[u]), 32'(en));
    check({tag, "_fail"}, 32'(of[u]), 32'(ef));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_data"}, 32'(od[u]), 32'(ed));
      check({tag, "_hold_valid"}, 32'(ov[u]), 32'd1);
      check({tag, "_hold_ready"}, 32'(ir[u]), 32'd0);
    end
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    check({tag, "_ready_after"}, 32'(ir[u]), 32'd1);
    check({tag, "_valid_after"}, 32'(ov[u]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [14:0] w;
    logic [14:0] ed;
    logic [1:0]  en;
    logic        ef;
    int          u;
    int          nf;

    for (int i = 0; i < 2; i++) begin
      iv[i]   = 1'b0;
      idt[i]  = '0;
      ordy[i] = 1'b0;
    end

    tbl[0] = '{15'h01D1, 15'h01D1, 2'd0, 1'b0};
    tbl[1] = '{15'h41D1, 15'h01D1, 2'd1, 1'b0};
    tbl[2] = '{15'h0021, 15'h0000, 2'd2, 1'b0};
    tbl[3] = '{15'h0421, 15'h0421, 2'd0, 1'b1};
    tbl[4] = '{15'h0000, 15'h0000, 2'd0, 1'b0};
    tbl[5] = '{15'h7FFE, 15'h7FFF, 2'd1, 1'b0};
    tbl[6] = '{15'h6FF7, 15'h7FFF, 2'd2, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", 32'(od[0]), 32'd0);
    check("rst_out_nerr", 32'(on[0]), 32'd0);
    check("rst_out_fail", 32'(of[0]), 32'd0);
    check("rst_in_ready_fast", 32'(ir[1]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_release_ready", 32'(ir[0]), 32'd1);

    // Table-driven vectors on the full-latency instance
    for (int i = 0; i < 7; i++) begin
      run(0, tbl[i].din, tbl[i].dout, tbl[i].nerr, tbl[i].fail, 17, 0, $sformatf("vec%0d", i));
    end

    // Fast-clean instance: clean words skip Chien, others keep full latency
    run(1, 15'h01D1, 15'h01D1, 2'd0, 1'b0, 2, 0, "fast_clean");
    run(1, 15'h41D1, 15'h01D1, 2'd1, 1'b0, 17, 1, "fast_single");
    run(1, 15'h0421, 15'h0421, 2'd0, 1'b1, 17, 0, "fast_uncorr");

    // Backpressure with the next word already waiting
    @(negedge clk);
    iv[0]  = 1'b1;
    idt[0] = 15'h41D1;
    @(posedge clk);
    #1;
    idt[0] = 15'h0021;
    lat = 0;
    while (!ov[0] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd17);
    for (int k = 0; k < 10; k++) begin
      check("bp_data", 32'(od[0]), 32'h01D1);
      check("bp_nerr", 32'(on[0]), 32'd1);
      check("bp_valid", 32'(ov[0]), 32'd1);
      check("bp_in_ready", 32'(ir[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    check("bp_ready_after", 32'(ir[0]), 32'd1);
    check("bp_valid_after", 32'(ov[0]), 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_accepted", 32'(ir[0]), 32'd0);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp2_latency", 32'(lat), 32'd17);
    check("bp2_data", 32'(od[0]), 32'h0000);
    check("bp2_nerr", 32'(on[0]), 32'd2);
    check("bp2_fail", 32'(of[0]), 32'd0);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;

    // Reset in the middle of the Chien search
    @(negedge clk);
    iv[0]  = 1'b1;
    idt[0] = 15'h41D1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("chien_busy", 32'(ir[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_in_ready", 32'(ir[0]), 32'd1);
    check("midrst_out_data", 32'(od[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 15'h0021, 15'h0000, 2'd2, 1'b0, 17, 0, "post_rst");

    // Randomized words against the nearest-codeword model
    for (int r = 0; r < 40; r++) begin
      w  = encode(7'($urandom_range(0, 127)));
      nf = int'($urandom_range(0, 3));
      for (int k = 0; k < nf; k++) begin
        w = w ^ (15'(1) << $urandom_range(0, 14));
      end
      ref_decode(w, ed, en, ef);
      u = int'($urandom_range(0, 1));
      lat = (u == 1 && !ef && en == 2'd0) ? 2 : 17;
      run(u, w, ed, en, ef, lat, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
